snf_rxreq: RTL and testbench
============================

# snf_rxreq

Request-channel receiver on the SNF side of the CHI link, directly downstream of the HN-F request transmitter. It accepts `reqflit_t` flits under L-credit flow control and buffers them in a DEPTH-entry in-order FIFO. It presents them to the SNF memory-controller front end over a valid/ready interface. It also generates and returns L-credits (`rxreqlcrdv`) so the HN-F transmitter never overruns the buffer.

## Interface
- `DEPTH`, 4: FIFO entries and maximum L-credits outstanding; legal range 2..15.
- `NODE_ID`, 7'd0: this SNF's node ID, compared against the incoming flit's `TgtID`.
- `CW`, `$clog2(DEPTH+1)`: width of the counters (derived, not overridden).

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (`reset==0` resets on the next clock edge).
- `rxreqflit`  in  `reqflit_t`  incoming request flit.
- `rxreqflitv`  in  1  flit valid; one flit per cycle, consumes one credit.
- `rxreqflitpend`  in  1  flit-pending hint; ignored functionally.
- `rxreqlcrdv`  out  1  L-credit grant; one credit per high cycle.
- `req_valid`  out  1  FIFO head valid toward the memory controller.
- `req_flit`  out  `reqflit_t`  FIFO head flit.
- `req_ready`  in  1  consumer accepts the head when `req_valid & req_ready`.
- `crd_outstanding`  out  CW  credits currently held by the transmitter.
- `err_overflow`  out  1  sticky: a flit arrived while `crd_outstanding==0`.
- `err_tgtid`  out  1  sticky: an accepted flit had `TgtID != NODE_ID`.

## Operation

**State**
- FIFO of DEPTH entries with `count` 0..DEPTH, a read pointer and a write pointer; pointers wrap modulo DEPTH.
- Credit counter `crd`.
- Registered `rxreqlcrdv`.

**Receive**
- On `rxreqflitv==1` with `crd>0`: push the flit and decrement `crd`.
- On `rxreqflitv==1` with `crd==0`: drop the flit, set `err_overflow`, leave `crd` and `count` unchanged.
- On any pushed flit with `TgtID != NODE_ID`: set `err_tgtid`. The flit is still queued.

**Drain**
- `req_valid = (count != 0)`; `req_flit` = entry at the read pointer.
- Pop on `req_valid & req_ready`.
- Push and pop in the same cycle leaves `count` unchanged, including when FIFO is full and a pop frees the slot.

**Credit counter**
- `crd_next = crd + rxreqlcrdv - (accepted flit)`.
- A credit issue and an accepted flit in the same cycle net to zero.

**Credit generation**
- `count_next` is the post-update FIFO occupancy.
- `rxreqlcrdv_next = (count_next + crd_next < DEPTH)`.
- At most one credit per cycle.
- Invariant: `count + crd <= DEPTH` at all times; a bench assertion checks this.

**Outputs**
- `crd_outstanding = crd`.
- The error flags are sticky and cleared only by reset.

## Timing
- Reset values: `rxreqlcrdv=0`, `req_valid=0`, `req_flit=0`, `crd_outstanding=0`, `err_overflow=0`, `err_tgtid=0`. The FIFO is empty and both pointers are 0.
- After reset release (first cycle with `reset==1` is cycle 0): `rxreqlcrdv` is high in cycles 1..DEPTH and low from cycle DEPTH+1 while idle.
- Flit latency: a flit accepted in cycle N is visible on `req_flit`/`req_valid` in cycle N+1 (without bypass).
- Credit return: a pop in cycle N gives `rxreqlcrdv=1` in cycle N+1.
- Reset asserted mid-operation: the FIFO is flushed and all outstanding credits are forgotten. The HN-F transmitter is reset in the same cycle by system convention.
- Output ordering is strictly FIFO (arrival order).

## Configuration
- Macro `SNF_RXREQ_BYPASS_EN`.
- Defined:
  - When `count==0` and `rxreqflitv` with `crd>0`: `req_valid=1` and `req_flit=rxreqflit` combinationally in the same cycle.
  - If `req_ready==1` that cycle, the flit is not written into the FIFO. The slot stays free, so `rxreqlcrdv` is high next cycle.
  - Otherwise the flit is pushed normally.
  - The error-flag rules are unchanged.
- Undefined: no combinational path from `rxreqflit*` to `req_*`; latency is exactly 1 cycle.

## Test plan
1. DEPTH=4, `req_ready=0`, release reset -> `rxreqlcrdv` high exactly cycles 1..4; `crd_outstanding` settles at 4; `req_valid=0`.
2. Send one flit (Opcode=ReadNoSnp, TxnID=0x12, Addr=0x1000, TgtID=NODE_ID) with `req_ready=1` -> next cycle `req_valid=1` with identical fields; popped; `rxreqlcrdv=1` the cycle after the pop; `crd_outstanding` returns to 4.
3. `req_ready=0`, send 4 flits TxnID 0..3 back-to-back -> `count=4`, `crd_outstanding=0`, no `rxreqlcrdv`. Then `req_ready=1` -> drains TxnID 0,1,2,3 in order over 4 cycles; 4 credits returned one per cycle.
4. With `crd_outstanding=0`, drive `rxreqflitv` -> `err_overflow=1` (sticky); FIFO contents and `count` unchanged.
5. Flit with TgtID=NODE_ID+1 -> `err_tgtid=1`; flit still delivered on `req_flit`.
6. With `SNF_RXREQ_BYPASS_EN`, empty FIFO, `req_ready=1`, flit TxnID=0x7 -> `req_valid=1` with TxnID=0x7 in the same cycle and `count` stays 0. Without the macro -> `req_valid` rises the next cycle.

Source files
------------

// File: rtl/snf_rxreq.sv
// CHI request-channel receiver on the SNF side: L-credit flow control, in-order FIFO,
// valid/ready drain. Optional same-cycle bypass of an empty FIFO under SNF_RXREQ_BYPASS_EN.
package snf_rxreq_pkg;
    typedef struct packed {
        logic [3:0]  qos;
        logic [6:0]  tgtid;
        logic [6:0]  srcid;
        logic [7:0]  txnid;
        logic [5:0]  opcode;
        logic [2:0]  size;
        logic [47:0] addr;
    } reqflit_t;

    localparam logic [5:0] OPC_READNOSNP = 6'h04;
endpackage

module snf_rxreq
    import snf_rxreq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter logic [6:0]  NODE_ID = 7'd0,
    localparam int         CW      = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  reqflit_t      rxreqflit,
    input  logic          rxreqflitv,
    input  logic          rxreqflitpend,
    output logic          rxreqlcrdv,
    output logic          req_valid,
    output reqflit_t      req_flit,
    input  logic          req_ready,
    output logic [CW-1:0] crd_outstanding,
    output logic          err_overflow,
    output logic          err_tgtid
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    reqflit_t       mem_r [DEPTH];
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  crd_r;
    logic           lcrdv_r;
    logic           err_overflow_r;
    logic           err_tgtid_r;

    logic           accept_s;
    logic           bypass_s;
    logic           push_s;
    logic           pop_s;
    logic [CW-1:0]  count_next_s;
    logic [CW-1:0]  crd_next_s;
    logic           lcrdv_next_s;
    logic           unused_pend_s;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    assign unused_pend_s = rxreqflitpend;

    // Accept/push/pop decisions, drain-side outputs and next credit state.
    always_comb begin
        accept_s  = rxreqflitv && (crd_r != '0);
        bypass_s  = 1'b0;
        req_valid = (count_r != '0);
        req_flit  = mem_r[rd_ptr_r];
`ifdef SNF_RXREQ_BYPASS_EN
        if ((count_r == '0) && accept_s) begin
            req_valid = 1'b1;
            req_flit  = rxreqflit;
            bypass_s  = req_ready;
        end else begin
            bypass_s  = 1'b0;
        end
`endif
        push_s       = accept_s && !bypass_s;
        pop_s        = (count_r != '0) && req_ready;
        count_next_s = count_r + CW'(push_s) - CW'(pop_s);
        crd_next_s   = crd_r + CW'(lcrdv_r) - CW'(accept_s);
        // Grant a credit whenever a slot is neither occupied nor already promised.
        lcrdv_next_s = (({1'b0, count_next_s} + {1'b0, crd_next_s}) < (CW + 1)'(DEPTH));
    end

    // FIFO storage, pointers, credit counter and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r       <= '0;
            wr_ptr_r       <= '0;
            count_r        <= '0;
            crd_r          <= '0;
            lcrdv_r        <= 1'b0;
            err_overflow_r <= 1'b0;
            err_tgtid_r    <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= rxreqflit;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_next_s;
            crd_r   <= crd_next_s;
            lcrdv_r <= lcrdv_next_s;
            if (rxreqflitv && (crd_r == '0)) begin
                err_overflow_r <= 1'b1;
            end
            if (accept_s && (rxreqflit.tgtid != NODE_ID)) begin
                err_tgtid_r <= 1'b1;
            end
        end
    end

    assign rxreqlcrdv      = lcrdv_r;
    assign crd_outstanding = crd_r;
    assign err_overflow    = err_overflow_r;
    assign err_tgtid       = err_tgtid_r;

endmodule

// File: tb/tb_snf_rxreq.sv
// Directed self-checking bench for snf_rxreq (DEPTH=4, NODE_ID=0); expectations follow
// SNF_RXREQ_BYPASS_EN when the bench is built with that macro.
module tb_snf_rxreq;
    import snf_rxreq_pkg::*;

    logic       clock;
    logic       reset;
    reqflit_t   rxreqflit;
    logic       rxreqflitv;
    logic       rxreqflitpend;
    logic       rxreqlcrdv;
    logic       req_valid;
    reqflit_t   req_flit;
    logic       req_ready;
    logic [2:0] crd_outstanding;
    logic       err_overflow;
    logic       err_tgtid;

    int n_checks = 0;
    int n_fail   = 0;

    snf_rxreq #(.DEPTH(4), .NODE_ID(7'd0)) dut (
        .clock           (clock),
        .reset           (reset),
        .rxreqflit       (rxreqflit),
        .rxreqflitv      (rxreqflitv),
        .rxreqflitpend   (rxreqflitpend),
        .rxreqlcrdv      (rxreqlcrdv),
        .req_valid       (req_valid),
        .req_flit        (req_flit),
        .req_ready       (req_ready),
        .crd_outstanding (crd_outstanding),
        .err_overflow    (err_overflow),
        .err_tgtid       (err_tgtid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic reqflit_t mk(input logic [6:0] tgt, input logic [7:0] txn,
                                    input logic [47:0] addr);
        reqflit_t f;
        f        = '0;
        f.tgtid  = tgt;
        f.srcid  = 7'd5;
        f.txnid  = txn;
        f.opcode = OPC_READNOSNP;
        f.addr   = addr;
        return f;
    endfunction

    // Occupancy plus outstanding credits can never exceed the buffer depth.
    always @(negedge clock) begin
        if (reset) begin
            n_checks++;
            assert (({1'b0, dut.count_r} + {1'b0, crd_outstanding}) <= 4'd4) else begin
                n_fail++;
                $error("FAIL invariant: observed %0d expected <= 4",
                       dut.count_r + crd_outstanding);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reqflit_t f;
        reset         = 1'b0;
        rxreqflit     = '0;
        rxreqflitv    = 1'b0;
        rxreqflitpend = 1'b0;
        req_ready     = 1'b0;
        repeat (3) tick();
        check("rst_lcrdv",  rxreqlcrdv, 0);
        check("rst_valid",  req_valid, 0);
        check("rst_flit",   req_flit, 0);
        check("rst_crd",    crd_outstanding, 0);
        check("rst_ovf",    err_overflow, 0);
        check("rst_tgt",    err_tgtid, 0);

        // Release: this is cycle 0; credits in cycles 1..4 only.
        reset = 1'b1;
        check("lcrdv_c0", rxreqlcrdv, 0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("lcrdv_c%0d", c), rxreqlcrdv, (c <= 4) ? 1 : 0);
        end
        check("crd_settled", crd_outstanding, 4);
        check("idle_valid", req_valid, 0);

        // Single flit with consumer ready.
        f = mk(7'd0, 8'h12, 48'h1000);
        rxreqflit     = f;
        rxreqflitv    = 1'b1;
        rxreqflitpend = 1'b1;
        req_ready     = 1'b1;
        #1;
`ifdef SNF_RXREQ_BYPASS_EN
        check("t2_byp_valid", req_valid, 1);
        check("t2_byp_flit", req_flit, f);
        tick();
        rxreqflitv    = 1'b0;
        rxreqflitpend = 1'b0;
        check("t2_valid_n1", req_valid, 0);
        check("t2_lcrdv_n1", rxreqlcrdv, 1);
        check("t2_crd_n1", crd_outstanding, 3);
`else
        check("t2_valid_n0", req_valid, 0);
        tick();
        rxreqflitv    = 1'b0;
        rxreqflitpend = 1'b0;
        check("t2_valid_n1", req_valid, 1);
        check("t2_flit_n1", req_flit, f);
        check("t2_crd_n1", crd_outstanding, 3);
        check("t2_lcrdv_n1", rxreqlcrdv, 0);
        tick();
        check("t2_valid_n2", req_valid, 0);
        check("t2_lcrdv_n2", rxreqlcrdv, 1);
        check("t2_crd_n2", crd_outstanding, 3);
`endif
        tick();
        check("t2_crd_back", crd_outstanding, 4);
        check("t2_lcrdv_off", rxreqlcrdv, 0);
        check("t2_ovf_clear", err_overflow, 0);
        check("t2_tgt_clear", err_tgtid, 0);

        // Fill the FIFO with the consumer stalled.
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rxreqflit  = mk(7'd0, 8'(i), 48'h2000 + 48'(i * 64));
            rxreqflitv = 1'b1;
            tick();
        end
        rxreqflitv = 1'b0;
        check("t3_crd_zero", crd_outstanding, 0);
        check("t3_lcrdv", rxreqlcrdv, 0);
        check("t3_valid", req_valid, 1);
        check("t3_head", req_flit.txnid, 0);

        // Flit with no credit available is dropped.
        rxreqflit  = mk(7'd0, 8'h55, 48'h3000);
        rxreqflitv = 1'b1;
        tick();
        rxreqflitv = 1'b0;
        check("t4_ovf", err_overflow, 1);
        check("t4_crd", crd_outstanding, 0);
        check("t4_head", req_flit.txnid, 0);
        tick();
        check("t4_ovf_sticky", err_overflow, 1);
        check("t4_lcrdv", rxreqlcrdv, 0);

        // Drain in arrival order, one credit back per pop.
        req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_drain_valid%0d", i), req_valid, 1);
            check($sformatf("t3_drain_txn%0d", i), req_flit.txnid, i);
            tick();
            check($sformatf("t3_drain_lcrdv%0d", i), rxreqlcrdv, 1);
        end
        check("t3_empty", req_valid, 0);
        tick();
        check("t3_lcrdv_done", rxreqlcrdv, 0);
        check("t3_crd_full", crd_outstanding, 4);
        check("t3_dropped_absent", req_valid, 0);

        // Wrong target: flagged but still delivered.
        req_ready  = 1'b0;
        rxreqflit  = mk(7'd1, 8'h21, 48'h4000);
        rxreqflitv = 1'b1;
        tick();
        rxreqflitv = 1'b0;
        check("t5_tgt_err", err_tgtid, 1);
        check("t5_valid", req_valid, 1);
        check("t5_tgtid", req_flit.tgtid, 1);
        check("t5_txn", req_flit.txnid, 8'h21);
        req_ready = 1'b1;
        tick();
        check("t5_popped", req_valid, 0);
        check("t5_tgt_sticky", err_tgtid, 1);
        repeat (3) tick();
        check("t6_pre_crd", crd_outstanding, 4);

        // Empty FIFO, consumer ready, TxnID 7.
        rxreqflit  = mk(7'd0, 8'h07, 48'h5000);
        rxreqflitv = 1'b1;
        #1;
`ifdef SNF_RXREQ_BYPASS_EN
        check("t6_same_valid", req_valid, 1);
        check("t6_same_txn", req_flit.txnid, 8'h07);
        tick();
        rxreqflitv = 1'b0;
        check("t6_count", dut.count_r, 0);
        check("t6_next_valid", req_valid, 0);
`else
        check("t6_same_valid", req_valid, 0);
        tick();
        rxreqflitv = 1'b0;
        check("t6_next_valid", req_valid, 1);
        check("t6_next_txn", req_flit.txnid, 8'h07);
        tick();
        check("t6_popped", req_valid, 0);
`endif

        // Reset mid-operation flushes FIFO and credits.
        req_ready  = 1'b0;
        rxreqflit  = mk(7'd0, 8'h33, 48'h6000);
        rxreqflitv = 1'b1;
        tick();
        rxreqflitv = 1'b0;
        check("t7_queued", req_valid, 1);
        reset = 1'b0;
        tick();
        check("t7_valid", req_valid, 0);
        check("t7_flit", req_flit, 0);
        check("t7_crd", crd_outstanding, 0);
        check("t7_ovf", err_overflow, 0);
        check("t7_tgt", err_tgtid, 0);
        check("t7_lcrdv", rxreqlcrdv, 0);
        reset = 1'b1;
        tick();
        check("t7_relcrdv", rxreqlcrdv, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
